// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch and
// data-access paths of the CPU. One transaction is outstanding at a time:
// the winning request is captured into a registered buffer in IDLE,
// presented on the mem_* port in REQ until memory accepts it, and its
// completion is routed back to the owning requester in WAIT.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//   undefined : strict data priority.
//   defined   : after STARVE_LIMIT consecutive data grants made while a
//               fetch was pending, the next grant goes to the fetch path.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   inst_req/inst_addr          fetch request and address
//   inst_addr_ok                fetch request accepted this cycle
//   inst_data_ok/inst_rdata     fetch data valid / fetch data
//   data_req/data_wr/data_wstrb/data_addr/data_wdata
//                               load/store request fields
//   data_addr_ok                load/store accepted this cycle
//   data_data_ok/data_rdata     load data valid or store done / load data
//   mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata
//                               registered request to memory
//   mem_addr_ok                 memory accepted the request
//   mem_data_ok/mem_rdata       memory completed the request / read data
//   arb_busy                    a transaction is in progress
module sram_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                arb_busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;   // 0 = inst, 1 = data
  logic                mem_req_reg, mem_req_next;
  logic                mem_wr_reg, mem_wr_next;
  logic [STRB_W-1:0]   mem_wstrb_reg, mem_wstrb_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;

  logic                force_inst;
  logic                grant_data;
  logic                grant_inst;
  logic                in_idle;

  assign in_idle = (state_reg == IDLE);

  // Data wins unless the starvation guard forces a fetch grant.
  assign grant_data = data_req && !force_inst;
  assign grant_inst = inst_req && !grant_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  assign force_inst = inst_req && (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  // Counts data grants that bypassed a waiting fetch. It cannot pass the
  // limit: at the limit a pending fetch wins, and a data grant with no
  // fetch pending clears it.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (in_idle) begin
      if (grant_inst) begin
        starve_cnt_next = '0;
      end else if (grant_data) begin
        starve_cnt_next = inst_req ? starve_cnt_reg + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  assign force_inst = 1'b0;
`endif

  // Next-state and request-buffer logic.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    mem_req_next   = mem_req_reg;
    mem_wr_next    = mem_wr_reg;
    mem_wstrb_next = mem_wstrb_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_data || grant_inst) begin
          state_next     = REQ;
          owner_next     = grant_data;
          mem_req_next   = 1'b1;
          // Fetches are always reads with no byte enables.
          mem_wr_next    = grant_data && data_wr;
          mem_wstrb_next = grant_data ? data_wstrb : '0;
          mem_addr_next  = grant_data ? data_addr  : inst_addr;
          mem_wdata_next = grant_data ? data_wdata : '0;
        end
      end
      REQ: begin
        if (mem_addr_ok) begin
          state_next   = WAIT;
          mem_req_next = 1'b0;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_wstrb_reg <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      mem_req_reg   <= mem_req_next;
      mem_wr_reg    <= mem_wr_next;
      mem_wstrb_reg <= mem_wstrb_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Handshakes are masked by resetn so a requester holding req high while
  // reset is asserted never sees an acceptance.
  assign inst_addr_ok = resetn && in_idle && grant_inst;
  assign data_addr_ok = resetn && in_idle && grant_data;

  // Completion only counts in WAIT; a stray mem_data_ok elsewhere is dropped.
  assign inst_data_ok = resetn && (state_reg == WAIT) && !owner_reg && mem_data_ok;
  assign data_data_ok = resetn && (state_reg == WAIT) &&  owner_reg && mem_data_ok;

  // Both read buses see memory directly; data_ok qualifies them.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign mem_req   = mem_req_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  assign arb_busy = !in_idle;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              inst_req = 1'b0;
  logic [ADDR_W-1:0] inst_addr = '0;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req = 1'b0;
  logic              data_wr = 1'b0;
  logic [3:0]        data_wstrb = '0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] data_wdata = '0;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok = 1'b0;
  logic              mem_data_ok = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              arb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  sram_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req),
    .data_wr(data_wr),
    .data_wstrb(data_wstrb),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (inst_data_ok) $display("txn inst done rdata=%08h", inst_rdata);
    if (data_data_ok) $display("txn data done rdata=%08h", data_rdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #12;
    chk("rst_mem_req",  mem_req,  1'b0);
    chk("rst_mem_wr",   mem_wr,   1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_busy",     arb_busy, 1'b0);
    chk("rst_iaok",     inst_addr_ok, 1'b0);
    chk("rst_daok",     data_addr_ok, 1'b0);
    step(); resetn = 1'b1;
    step();

    // ---------------- single fetch ----------------
    step(); inst_req = 1'b1; inst_addr = 32'h1C00_0000; settle();
    chk("f1_iaok", inst_addr_ok, 1'b1);
    chk("f1_daok", data_addr_ok, 1'b0);
    chk("f1_memreq_T", mem_req, 1'b0);
    step(); inst_req = 1'b0; inst_addr = '0; mem_addr_ok = 1'b1; settle();
    chk("f1_memreq", mem_req, 1'b1);
    chk("f1_memaddr", mem_addr, 32'h1C00_0000);
    chk("f1_memwr", mem_wr, 1'b0);
    chk("f1_busy", arb_busy, 1'b1);
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0421; settle();
    chk("f1_idok", inst_data_ok, 1'b1);
    chk("f1_irdata", inst_rdata, 32'h0280_0421);
    chk("f1_ddok", data_data_ok, 1'b0);
    chk("f1_memreq_wait", mem_req, 1'b0);
    step(); mem_data_ok = 1'b0; settle();
    chk("f1_idle", arb_busy, 1'b0);
    chk("f1_idok_once", inst_data_ok, 1'b0);

    // ---------------- simultaneous requests ----------------
    step();
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C00_8000; data_wstrb = 4'h0;
    settle();
    chk("s_daok", data_addr_ok, 1'b1);
    chk("s_iaok_lose", inst_addr_ok, 1'b0);
    step(); data_req = 1'b0; mem_addr_ok = 1'b1; settle();
    chk("s_memaddr_d", mem_addr, 32'h1C00_8000);
    chk("s_memwr_d", mem_wr, 1'b0);
    chk("s_iaok_req", inst_addr_ok, 1'b0);
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; settle();
    chk("s_ddok", data_data_ok, 1'b1);
    chk("s_drdata", data_rdata, 32'h1111_2222);
    chk("s_idok_notyet", inst_data_ok, 1'b0);
    step(); mem_data_ok = 1'b0; settle();
    chk("s_iaok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0; mem_addr_ok = 1'b1; settle();
    chk("s_memaddr_i", mem_addr, 32'h1C00_0004);
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3333_4444; settle();
    chk("s_idok", inst_data_ok, 1'b1);
    chk("s_ddok_not", data_data_ok, 1'b0);
    chk("s_irdata", inst_rdata, 32'h3333_4444);
    step(); mem_data_ok = 1'b0;

    // ---------------- store with backpressure ----------------
    step();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h1C00_0100; data_wdata = 32'hDEAD_BEEF;
    settle();
    chk("st_daok", data_addr_ok, 1'b1);
    step();
    // Scramble the requester fields: the buffer must not follow them.
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = '0; data_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      mem_addr_ok = (i == 3);
      settle();
      chk("st_memreq", mem_req, 1'b1);
      chk("st_memwr", mem_wr, 1'b1);
      chk("st_wstrb", mem_wstrb, 4'hF);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_addr", mem_addr, 32'h1C00_0100);
    end
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0; settle();
    chk("st_ddok", data_data_ok, 1'b1);
    chk("st_memreq_off", mem_req, 1'b0);
    step(); mem_data_ok = 1'b0; settle();
    chk("st_ddok_once", data_data_ok, 1'b0);
    chk("st_idle", arb_busy, 1'b0);

    // ---------------- reset mid-WAIT ----------------
    step(); inst_req = 1'b1; inst_addr = 32'h1C00_0200; settle();
    chk("rw_iaok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0; mem_addr_ok = 1'b1;
    step(); mem_addr_ok = 1'b0; settle();
    chk("rw_wait_busy", arb_busy, 1'b1);
    resetn = 1'b0; inst_req = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rw_busy", arb_busy, 1'b0);
    chk("rw_memreq", mem_req, 1'b0);
    chk("rw_memaddr", mem_addr, 32'h0);
    chk("rw_iaok", inst_addr_ok, 1'b0);
    chk("rw_idok", inst_data_ok, 1'b0);
    step();
    step(); resetn = 1'b1; inst_req = 1'b0; settle();
    chk("rw_idok_rel", inst_data_ok, 1'b0);
    chk("rw_ddok_rel", data_data_ok, 1'b0);
    step(); mem_data_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C00_0300; settle();
    chk("rw_next_daok", data_addr_ok, 1'b1);
    step(); data_req = 1'b0; mem_addr_ok = 1'b1; settle();
    chk("rw_next_addr", mem_addr, 32'h1C00_0300);
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA; settle();
    chk("rw_next_ddok", data_data_ok, 1'b1);
    chk("rw_next_rdata", data_rdata, 32'h55AA_55AA);
    step(); mem_data_ok = 1'b0;

    // ---------------- stray mem_data_ok in IDLE and REQ ----------------
    step(); mem_data_ok = 1'b1; settle();
    chk("sx_idle_idok", inst_data_ok, 1'b0);
    chk("sx_idle_ddok", data_data_ok, 1'b0);
    chk("sx_idle_busy", arb_busy, 1'b0);
    step(); inst_req = 1'b1; inst_addr = 32'h1C00_0400; settle();
    chk("sx_iaok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0; settle();
    chk("sx_req_idok", inst_data_ok, 1'b0);
    chk("sx_req_memreq", mem_req, 1'b1);
    step(); settle();
    chk("sx_req_hold", mem_req, 1'b1);
    chk("sx_req_idok2", inst_data_ok, 1'b0);
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
    chk("sx_idok", inst_data_ok, 1'b1);
    step(); mem_data_ok = 1'b0;

    // ---------------- grant order with both requesters held ----------------
    for (int g = 0; g < 10; g++) begin
      logic exp_data;
`ifdef ARB_STARVE_GUARD_EN
      exp_data = ((g % 5) != 4);
`else
      exp_data = 1'b1;
`endif
      step(); mem_data_ok = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1C00_1000;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C00_9000;
      settle();
      $display("grant %0d: %s", g, data_addr_ok ? "D" : (inst_addr_ok ? "I" : "-"));
      chk("g_daok", data_addr_ok, exp_data);
      chk("g_iaok", inst_addr_ok, !exp_data);
      step(); mem_addr_ok = 1'b1;
      step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'(g);
    end
    step(); mem_data_ok = 1'b0; data_req = 1'b0; settle();
    chk("g_inst_after", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0; mem_addr_ok = 1'b1;
    step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_1234; settle();
    chk("g_inst_done", inst_data_ok, 1'b1);
    step(); mem_data_ok = 1'b0; settle();
    chk("g_final_idle", arb_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
